id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  Decode->execute pipeline register plus execute operand forwarding, directly upstream of the ALU.
//  Registers decoded operands/control on each clk; supports stall (hold) and flush (bubble).
//  Resolves RAW hazards by muxing forwarded M/W results, then drives SrcAE/SrcBE/ALUcontrolE.
// PARAMETERS
//  WIDTH  32  datapath width (operands, immediate, PC, results)
//  CNT_W  16  width of bubble counter (only with IDEX_PERF_CNT_EN)
// PORTS
//  clk          in   1      pipeline clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  StallE       in   1      hold all E registers this edge
//  FlushE       in   1      load a bubble this edge
//  ValidD       in   1      decode slot holds a real instruction
//  RD1D, RD2D   in   WIDTH  register-file read data
//  ImmExtD      in   WIDTH  sign-extended immediate
//  PCD          in   WIDTH  instruction PC
//  Rs1D,Rs2D,RdD in  5      register addresses
//  ALUcontrolD  in   3      ALU op (000 add, 001 sub, 010 and, 100 xor)
//  ALUSrcD      in   1      1: SrcB = immediate
//  CtrlD        in   5      {RegWrite, MemWrite, Branch, ResultSrc[1:0]}
//  ForwardAE    in   2      A select: 00 reg, 10 ALUResultM, 01 ResultW, 11 reg
//  ForwardBE    in   2      B select, same encoding
//  ALUResultM   in   WIDTH  memory-stage ALU result
//  ResultW      in   WIDTH  writeback-stage result
//  SrcAE,SrcBE  out  WIDTH  ALU operands (combinational from E regs + forwards)
//  ALUcontrolE  out  3      registered ALU op
//  WriteDataE   out  WIDTH  forwarded RD2 for stores
//  ImmExtE,PCE  out  WIDTH  registered immediate / PC
//  Rs1E,Rs2E,RdE out 5      registered addresses (to hazard unit)
//  CtrlE        out  5      registered control
//  ValidE       out  1      E slot valid
// BEHAVIOUR
//  - Reset (rst_n=0, async, immediate): all E registers 0 -> ValidE=0, CtrlE=0, ALUcontrolE=000.
//  - Per edge, priority FlushE > StallE > load: flush -> all E regs 0 (bubble, add of 0+0, no
//    writes); stall -> hold; else load *D values. Latency 1 cycle D->E.
//  - FlushE & StallE same edge: flush wins.
//  - ValidD=0 with load: loads regs, forces CtrlE=0, ValidE=0.
//  - FwdA = ForwardAE mux of {RD1E, ALUResultM, ResultW}; 11 treated as 00. Same for FwdB.
//  - SrcAE = FwdA; SrcBE = ALUSrcE ? ImmExtE : FwdB; WriteDataE = FwdB always.
//  - Forwarding is purely combinational, same cycle; no width change, no arithmetic here.
//  - Outputs glitch-free w.r.t. reset: deassertion applies on next edge only.
// CONFIGURATION
//  IDEX_PERF_CNT_EN defined: extra port BubbleCntE out CNT_W; increments on each edge where
//    E loads a bubble (FlushE=1, or load with ValidD=0); holds on stall; saturates at all-ones;
//    async reset to 0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset mid-run: rst_n=0 while ValidE=1 -> all outputs 0 same cycle, no clk edge needed.
//  2 Load: RD1D=5, RD2D=7, ALUSrcD=0, Fwd=00 -> next cycle SrcAE=5, SrcBE=7, ValidE=1.
//  3 Forward: ForwardAE=10, ALUResultM=0x20; ForwardBE=01, ResultW=0x30, ALUSrcE=1, ImmExtE=4
//    -> SrcAE=0x20, SrcBE=4, WriteDataE=0x30.
//  4 Stall 3 cycles with changing D inputs -> E outputs unchanged; then load new values.
//  5 FlushE=StallE=1 with CtrlD=5'b11000 -> CtrlE=0, ValidE=0, ALUcontrolE=000.
//  6 IDEX_PERF_CNT_EN: 3 flushes + 1 ValidD=0 load -> BubbleCntE=4; preset near max -> saturates.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode->execute boundary bundle: decode-side operands/control in, registered E slot out.
// IDEX_PERF_CNT_EN adds the BubbleCntE counter output (width CNT_W).
interface id_ex_stage_if #(
  parameter int WIDTH = 32
`ifdef IDEX_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic             StallE, FlushE, ValidD;
  logic [WIDTH-1:0] RD1D, RD2D, ImmExtD, PCD;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic [2:0]       ALUcontrolD;
  logic             ALUSrcD;
  logic [4:0]       CtrlD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [WIDTH-1:0] ALUResultM, ResultW;

  logic [WIDTH-1:0] SrcAE, SrcBE, WriteDataE, ImmExtE, PCE;
  logic [2:0]       ALUcontrolE;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [4:0]       CtrlE;
  logic             ValidE;
`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] BubbleCntE;
`endif

  modport master (
    output StallE, FlushE, ValidD, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD,
           ALUcontrolD, ALUSrcD, CtrlD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    input  SrcAE, SrcBE, WriteDataE, ImmExtE, PCE, ALUcontrolE, Rs1E, Rs2E, RdE,
           CtrlE, ValidE
`ifdef IDEX_PERF_CNT_EN
    , input BubbleCntE
`endif
  );

  modport slave (
    input  StallE, FlushE, ValidD, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD,
           ALUcontrolD, ALUSrcD, CtrlD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    output SrcAE, SrcBE, WriteDataE, ImmExtE, PCE, ALUcontrolE, Rs1E, Rs2E, RdE,
           CtrlE, ValidE
`ifdef IDEX_PERF_CNT_EN
    , output BubbleCntE
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall and combinational M/W operand forwarding.
// IDEX_PERF_CNT_EN enables a saturating bubble counter on BubbleCntE.
module id_ex_stage #(
  parameter int WIDTH = 32
`ifdef IDEX_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave io
);

  typedef struct packed {
    logic             valid;
    logic [4:0]       ctrl;
    logic [2:0]       alu_ctrl;
    logic             alu_src;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
  } e_slot_t;

  e_slot_t e_q, e_d;
  logic    bubble;

  // Flush beats stall; an invalid decode slot still loads data but never writes anything.
  always_comb begin
    e_d = e_q;
    if (io.FlushE) begin
      e_d = '0;
    end else if (!io.StallE) begin
      e_d.valid    = io.ValidD;
      e_d.ctrl     = io.ValidD ? io.CtrlD : 5'b0;
      e_d.alu_ctrl = io.ALUcontrolD;
      e_d.alu_src  = io.ALUSrcD;
      e_d.rd1      = io.RD1D;
      e_d.rd2      = io.RD2D;
      e_d.imm      = io.ImmExtD;
      e_d.pc       = io.PCD;
      e_d.rs1      = io.Rs1D;
      e_d.rs2      = io.Rs2D;
      e_d.rd       = io.RdD;
    end
  end

  assign bubble = io.FlushE | (!io.StallE & !io.ValidD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

  // 10 = memory stage, 01 = writeback; 00 and 11 both take the register value.
  function automatic logic [WIDTH-1:0] fwd_pick(input logic [1:0]       sel,
                                                input logic [WIDTH-1:0] reg_val,
                                                input logic [WIDTH-1:0] mem_val,
                                                input logic [WIDTH-1:0] wb_val);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b10:   r = mem_val;
      2'b01:   r = wb_val;
      default: r = reg_val;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] fwd_a, fwd_b;

  assign fwd_a = fwd_pick(io.ForwardAE, e_q.rd1, io.ALUResultM, io.ResultW);
  assign fwd_b = fwd_pick(io.ForwardBE, e_q.rd2, io.ALUResultM, io.ResultW);

  assign io.SrcAE       = fwd_a;
  assign io.SrcBE       = e_q.alu_src ? e_q.imm : fwd_b;
  assign io.WriteDataE  = fwd_b;
  assign io.ImmExtE     = e_q.imm;
  assign io.PCE         = e_q.pc;
  assign io.ALUcontrolE = e_q.alu_ctrl;
  assign io.Rs1E        = e_q.rs1;
  assign io.Rs2E        = e_q.rs2;
  assign io.RdE         = e_q.rd;
  assign io.CtrlE       = e_q.ctrl;
  assign io.ValidE      = e_q.valid;

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] bub_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        bub_cnt <= '0;
    else if (bubble && bub_cnt != '1) bub_cnt <= bub_cnt + 1'b1;
  end

  assign io.BubbleCntE = bub_cnt;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule
